operand_fetch: RTL

Operand fetch sequencer that drives the CPU register file's read and write ports. It accepts decoded register fields over a valid/ready handshake and presents the register addresses to the register file. It waits out the one-cycle synchronous read, forwards same-cycle writeback data that the register file cannot yet return, and delivers both 16-bit operands downstream over a second valid/ready handshake. It sits between decode and execute, and it is the only master of the register file ports.

---
 rtl/operand_fetch_if.sv | 49 ++++
 rtl/operand_fetch.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/operand_fetch_if.sv
// Signal bundle between operand_fetch and its neighbours: decode, writeback,
// register file and execute. The fetch block uses the slave view.
interface operand_fetch_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_rs_a;
    logic [2:0]  in_rs_b;
    logic [2:0]  in_rd;

    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;

    logic        rf_write_enabled;
    logic [2:0]  rf_addr_dest;
    logic [15:0] rf_write_data;
    logic [2:0]  rf_addr_reg_a;
    logic [2:0]  rf_addr_reg_b;
    logic [15:0] rf_out_reg_a;
    logic [15:0] rf_out_reg_b;

    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_op_a;
    logic [15:0] out_op_b;
    logic [2:0]  out_rd;

    modport slave (
        input  in_valid, in_rs_a, in_rs_b, in_rd,
        input  wb_valid, wb_rd, wb_data,
        input  rf_out_reg_a, rf_out_reg_b,
        input  out_ready,
        output in_ready,
        output rf_write_enabled, rf_addr_dest, rf_write_data,
        output rf_addr_reg_a, rf_addr_reg_b,
        output out_valid, out_op_a, out_op_b, out_rd
    );

    modport master (
        output in_valid, in_rs_a, in_rs_b, in_rd,
        output wb_valid, wb_rd, wb_data,
        output rf_out_reg_a, rf_out_reg_b,
        output out_ready,
        input  in_ready,
        input  rf_write_enabled, rf_addr_dest, rf_write_data,
        input  rf_addr_reg_a, rf_addr_reg_b,
        input  out_valid, out_op_a, out_op_b, out_rd
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch sequencer: addresses the register file, waits out its read, forwards writebacks.
// OPFETCH_BYPASS_EN selects bypass registers; without it a colliding writeback forces a re-read.
//
// state | meaning
// IDLE  | no fetch in flight, ready for decode
// READ  | addresses presented, register file samples them at the closing edge
// LOAD  | register file data valid, operands captured at the closing edge
// VALID | operands presented downstream, tracking writebacks until taken
module operand_fetch (
    input  logic           clk,
    input  logic           rst,
    operand_fetch_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, LOAD, VALID} state_t;

    state_t      state_q, state_d;
    logic [2:0]  addr_a_q, addr_a_d;
    logic [2:0]  addr_b_q, addr_b_d;
    logic [2:0]  rd_q, rd_d;
    logic [15:0] op_a_q, op_a_d;
    logic [15:0] op_b_q, op_b_d;
`ifdef OPFETCH_BYPASS_EN
    logic        byp_a_valid_q, byp_a_valid_d;
    logic        byp_b_valid_q, byp_b_valid_d;
    logic [15:0] byp_a_data_q, byp_a_data_d;
    logic [15:0] byp_b_data_q, byp_b_data_d;
`endif

    logic wb_hit_a;
    logic wb_hit_b;
    logic in_ready;
    logic accept;

    assign wb_hit_a = bus.wb_valid && (bus.wb_rd == addr_a_q);
    assign wb_hit_b = bus.wb_valid && (bus.wb_rd == addr_b_q);
    assign in_ready = (state_q == IDLE) || ((state_q == VALID) && bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        rd_d     = rd_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
`ifdef OPFETCH_BYPASS_EN
        byp_a_valid_d = byp_a_valid_q;
        byp_b_valid_d = byp_b_valid_q;
        byp_a_data_d  = byp_a_data_q;
        byp_b_data_d  = byp_b_data_q;
`endif

        case (state_q)
            IDLE: ;
            READ: begin
`ifdef OPFETCH_BYPASS_EN
                // Register file returns the old value for a write on the sampling edge.
                byp_a_valid_d = wb_hit_a;
                byp_b_valid_d = wb_hit_b;
                byp_a_data_d  = bus.wb_data;
                byp_b_data_d  = bus.wb_data;
                state_d       = LOAD;
`else
                state_d = (wb_hit_a || wb_hit_b) ? READ : LOAD;
`endif
            end
            LOAD: begin
`ifdef OPFETCH_BYPASS_EN
                op_a_d  = wb_hit_a      ? bus.wb_data  :
                          byp_a_valid_q ? byp_a_data_q : bus.rf_out_reg_a;
                op_b_d  = wb_hit_b      ? bus.wb_data  :
                          byp_b_valid_q ? byp_b_data_q : bus.rf_out_reg_b;
                state_d = VALID;
`else
                if (wb_hit_a || wb_hit_b) begin
                    state_d = READ;
                end else begin
                    op_a_d  = bus.rf_out_reg_a;
                    op_b_d  = bus.rf_out_reg_b;
                    state_d = VALID;
                end
`endif
            end
            VALID: begin
                if (wb_hit_a) op_a_d = bus.wb_data;
                if (wb_hit_b) op_b_d = bus.wb_data;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Acceptance only happens from IDLE or a completing VALID handshake.
        if (accept) begin
            addr_a_d = bus.in_rs_a;
            addr_b_d = bus.in_rs_b;
            rd_d     = bus.in_rd;
            state_d  = READ;
`ifdef OPFETCH_BYPASS_EN
            byp_a_valid_d = 1'b0;
            byp_b_valid_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_a_q <= 3'd0;
            addr_b_q <= 3'd0;
            rd_q     <= 3'd0;
            op_a_q   <= 16'd0;
            op_b_q   <= 16'd0;
`ifdef OPFETCH_BYPASS_EN
            byp_a_valid_q <= 1'b0;
            byp_b_valid_q <= 1'b0;
            byp_a_data_q  <= 16'd0;
            byp_b_data_q  <= 16'd0;
`endif
        end else begin
            state_q  <= state_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            rd_q     <= rd_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
`ifdef OPFETCH_BYPASS_EN
            byp_a_valid_q <= byp_a_valid_d;
            byp_b_valid_q <= byp_b_valid_d;
            byp_a_data_q  <= byp_a_data_d;
            byp_b_data_q  <= byp_b_data_d;
`endif
        end
    end

    assign bus.in_ready         = in_ready;
    assign bus.rf_write_enabled = bus.wb_valid && !rst;
    assign bus.rf_addr_dest     = bus.wb_rd;
    assign bus.rf_write_data    = bus.wb_data;
    assign bus.rf_addr_reg_a    = addr_a_q;
    assign bus.rf_addr_reg_b    = addr_b_q;
    assign bus.out_valid        = (state_q == VALID);
    assign bus.out_op_a         = op_a_q;
    assign bus.out_op_b         = op_b_q;
    assign bus.out_rd           = rd_q;
endmodule
